// File: rtl/sifive_reset_request.sv
// sifive_reset_request: upstream reset-request stage on the free-running board clock.
// Holds areset high until all PLLs are locked, the lock has been stable for
// STABLE_CYCLES, and no pushbutton or software reset request is pending.
// Keeps a sticky reset-cause register for debug.
// Optional build macro: RESET_LOCK_REARM_EN -- when defined, lock loss in RUN
// re-enters ASSERT; when undefined, lock loss in RUN is only recorded in cause[2].
module sifive_reset_request #(
  parameter int unsigned N_LOCKS           = 2,
  parameter int unsigned BTN_DEBOUNCE_BITS = 16,
  parameter int unsigned MIN_ASSERT_CYCLES = 64,
  parameter int unsigned STABLE_CYCLES     = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_LOCKS-1:0] pll_locked,
  input  logic               button,
  input  logic               sw_req,
  input  logic               cause_clr,
  output logic               areset,
  output logic [1:0]         state,
  output logic [2:0]         cause
);

  // Shared FSM counter covers the longer of the two timed states.
  localparam int unsigned CNT_MAX = (MIN_ASSERT_CYCLES > STABLE_CYCLES) ?
                                    MIN_ASSERT_CYCLES : STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned DB_W    = BTN_DEBOUNCE_BITS;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = '1;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [N_LOCKS-1:0] lock_s1, lock_s2;
  logic               btn_s1, btn_s2;
  logic [DB_W-1:0]    db_cnt;
  logic               btn_db, btn_db_q;
  logic               lock_ok_q;
  state_t             state_q;
  logic [CNT_W-1:0]   cnt;
  logic               areset_q;
  logic [2:0]         cause_q;

  logic lock_ok;
  logic btn_rise;
  logic req;
  logic lock_lost;

  assign lock_ok   = &lock_s2;
  assign btn_rise  = btn_db & ~btn_db_q;
  assign req       = sw_req | btn_rise;
  assign lock_lost = lock_ok_q & ~lock_ok & (state_q == ST_RUN);

  assign areset = areset_q;
  assign state  = state_q;
  assign cause  = cause_q;

  // Two-flop synchronizers for the asynchronous lock and button inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_s1   <= '0;
      lock_s2   <= '0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      lock_ok_q <= 1'b0;
    end else begin
      lock_s1   <= pll_locked;
      lock_s2   <= lock_s1;
      btn_s1    <= button;
      btn_s2    <= btn_s1;
      lock_ok_q <= lock_ok;
    end
  end

  // Button debounce: btn_db follows the synced button after a full quiet window.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s2 != btn_db) begin
        if (db_cnt == DB_LAST) begin
          btn_db <= ~btn_db;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Reset-request FSM; areset is registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_ASSERT;
      cnt      <= '0;
      areset_q <= 1'b1;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (req) begin
            cnt <= '0;
          end else if (cnt == MIN_LAST) begin
            state_q <= ST_WAIT_LOCK;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (req) begin
            state_q <= ST_ASSERT;
            cnt     <= '0;
          end else if (lock_ok && !btn_db) begin
            state_q <= ST_STABLE;
            cnt     <= '0;
          end
        end
        ST_STABLE: begin
          if (req) begin
            state_q <= ST_ASSERT;
            cnt     <= '0;
          end else if (!lock_ok || btn_db) begin
            state_q <= ST_WAIT_LOCK;
            cnt     <= '0;
          end else if (cnt == STB_LAST) begin
            state_q  <= ST_RUN;
            cnt      <= '0;
            areset_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (req) begin
            state_q  <= ST_ASSERT;
            cnt      <= '0;
            areset_q <= 1'b1;
          end
`ifdef RESET_LOCK_REARM_EN
          else if (!lock_ok) begin
            state_q  <= ST_ASSERT;
            cnt      <= '0;
            areset_q <= 1'b1;
          end
`endif
        end
        default: begin
          state_q  <= ST_ASSERT;
          cnt      <= '0;
          areset_q <= 1'b1;
        end
      endcase
    end
  end

  // Sticky reset cause; a same-cycle set wins over cause_clr.
  always_ff @(posedge clock) begin
    if (reset) begin
      cause_q <= 3'b000;
    end else begin
      cause_q <= (cause_clr ? 3'b000 : cause_q) | {lock_lost, sw_req, btn_rise};
    end
  end

endmodule

// File: tb/tb_sifive_reset_request.sv
// Directed scoreboard bench for sifive_reset_request (4/8 timing, 3-bit debounce).
module tb_sifive_reset_request;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] pll_locked;
  logic       button;
  logic       sw_req;
  logic       cause_clr;
  logic       areset;
  logic [1:0] state;
  logic [2:0] cause;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  sifive_reset_request #(
    .N_LOCKS(2),
    .BTN_DEBOUNCE_BITS(3),
    .MIN_ASSERT_CYCLES(4),
    .STABLE_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pll_locked(pll_locked),
    .button(button),
    .sw_req(sw_req),
    .cause_clr(cause_clr),
    .areset(areset),
    .state(state),
    .cause(cause)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pk(input logic a, input logic [1:0] s, input logic [2:0] c);
    return 32'({a, s, c});
  endfunction

  function automatic logic [31:0] outs();
    return 32'({areset, state, cause});
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_errors++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  // Counts edges until state reaches tgt; an expired budget returns max_edges.
  task automatic wait_state(input logic [1:0] tgt, input int max_edges, output int edges);
    edges = 0;
    do begin
      step(1);
      edges++;
    end while (state !== tgt && edges < max_edges);
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 2'b11;
    button     = 1'b0;
    sw_req     = 1'b0;
    cause_clr  = 1'b0;

    // Reset values and release timing: 4 + 1 + 8 = 13 edges
    push("reset_vals", pk(1'b1, 2'd0, 3'b000));
    step(3);
    pop_cmp(outs());
    reset = 1'b0;
    push("edge12_held", pk(1'b1, 2'd2, 3'b000));
    step(12);
    pop_cmp(outs());
    push("edge13_release", pk(1'b0, 2'd3, 3'b000));
    step(1);
    pop_cmp(outs());

    // Software request in RUN, then cause clear and set-beats-clear
    sw_req = 1'b1;
    push("sw_req_assert", pk(1'b1, 2'd0, 3'b010));
    step(1);
    sw_req = 1'b0;
    pop_cmp(outs());
    cause_clr = 1'b1;
    push("cause_clr", pk(1'b1, 2'd0, 3'b000));
    step(1);
    cause_clr = 1'b0;
    pop_cmp(outs());
    sw_req    = 1'b1;
    cause_clr = 1'b1;
    push("set_beats_clr", pk(1'b1, 2'd0, 3'b010));
    step(1);
    sw_req    = 1'b0;
    cause_clr = 1'b0;
    pop_cmp(outs());
    cause_clr = 1'b1;
    push("clr_again", pk(1'b1, 2'd0, 3'b000));
    step(1);
    cause_clr = 1'b0;
    pop_cmp(outs());
    push("sw_rerelease_latency", 32'd12);
    wait_state(2'd3, 50, n);
    pop_cmp(32'(n));
    push("sw_rerelease_out", pk(1'b0, 2'd3, 3'b000));
    pop_cmp(outs());

    // Locks low after reset: held in WAIT_LOCK, then 2 sync edges + 1
    reset      = 1'b1;
    pll_locked = 2'b00;
    step(2);
    reset = 1'b0;
    push("wait_lock_hold", pk(1'b1, 2'd1, 3'b000));
    step(50);
    pop_cmp(outs());
    pll_locked = 2'b11;
    push("lock_sync_latency", 32'd3);
    wait_state(2'd2, 20, n);
    pop_cmp(32'(n));
    push("stable_to_run", 32'd8);
    wait_state(2'd3, 20, n);
    pop_cmp(32'(n));
    push("lock_run_out", pk(1'b0, 2'd3, 3'b000));
    pop_cmp(outs());

    // One-cycle lock glitch during STABLE restarts the stable window
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    push("stable_entry", 32'd5);
    wait_state(2'd2, 20, n);
    pop_cmp(32'(n));
    step(3);
    pll_locked = 2'b01;
    step(1);
    pll_locked = 2'b11;
    push("glitch_to_wait", 32'd2);
    wait_state(2'd1, 10, n);
    pop_cmp(32'(n));
    push("glitch_restable", 32'd1);
    wait_state(2'd2, 10, n);
    pop_cmp(32'(n));
    push("glitch_run", 32'd8);
    wait_state(2'd3, 20, n);
    pop_cmp(32'(n));

    // Short button glitch is filtered out
    button = 1'b1;
    step(6);
    button = 1'b0;
    push("btn_glitch_ignored", pk(1'b0, 2'd3, 3'b000));
    step(10);
    pop_cmp(outs());

    // Button held 20 cycles: 2 sync + 8 debounce + 1 edge to ASSERT
    button = 1'b1;
    push("btn_assert_latency", 32'd11);
    wait_state(2'd0, 30, n);
    pop_cmp(32'(n));
    push("btn_assert_out", pk(1'b1, 2'd0, 3'b001));
    pop_cmp(outs());
    push("btn_held_wait", pk(1'b1, 2'd1, 3'b001));
    step(9);
    pop_cmp(outs());
    button = 1'b0;
    push("btn_release_latency", 32'd11);
    wait_state(2'd2, 30, n);
    pop_cmp(32'(n));
    push("btn_release_run", 32'd8);
    wait_state(2'd3, 20, n);
    pop_cmp(32'(n));
    push("btn_run_out", pk(1'b0, 2'd3, 3'b001));
    pop_cmp(outs());

    // Lock loss in RUN
    cause_clr = 1'b1;
    step(1);
    cause_clr = 1'b0;
    pll_locked = 2'b10;
    push("lockloss_pre", pk(1'b0, 2'd3, 3'b000));
    step(2);
    pop_cmp(outs());
`ifdef RESET_LOCK_REARM_EN
    push("lockloss_edge3", pk(1'b1, 2'd0, 3'b100));
    step(1);
    pop_cmp(outs());
    push("lockloss_later", pk(1'b1, 2'd1, 3'b100));
    step(5);
    pop_cmp(outs());
`else
    push("lockloss_edge3", pk(1'b0, 2'd3, 3'b100));
    step(1);
    pop_cmp(outs());
    push("lockloss_later", pk(1'b0, 2'd3, 3'b100));
    step(5);
    pop_cmp(outs());
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
